// File: rtl/rom_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port ROM with a one-cycle read latency.
// Out-of-range or misaligned addresses complete with err set and never reach the ROM.
module rom_arbiter #(
  parameter int unsigned SIZE = 64000
) (
  input  logic        mclk,
  input  logic        reset_n,
  input  logic [1:0]  req,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  output logic [1:0]  done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic        rom_enable,
  output logic [31:0] rom_address,
  input  logic [31:0] rom_data
);

  localparam logic [31:0] MaxAddr = 32'(SIZE - 4);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [1:0]  done_q, done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        rom_enable_q, rom_enable_d;
  logic [31:0] rom_address_q, rom_address_d;

  logic        winner;
  logic [31:0] sel_addr;
  logic        sel_valid;

  // On a tie, grant whoever was not served last.
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_q;
      default: winner = 1'b0;
    endcase
  end

  assign sel_addr  = winner ? addr1 : addr0;
  assign sel_valid = (sel_addr[1:0] == 2'b00) && (sel_addr <= MaxAddr);

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    done_d        = done_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    rom_enable_d  = 1'b0;
    rom_address_d = rom_address_q;

    unique case (state_q)
      StIdle: begin
        if (req != 2'b00) begin
          owner_d = winner;
          if (sel_valid) begin
            state_d       = StIssue;
            rom_enable_d  = 1'b1;
            rom_address_d = sel_addr;
          end else begin
            state_d = StResp;
            done_d  = winner ? 2'b10 : 2'b01;
            rdata_d = 32'h0;
            err_d   = 1'b1;
          end
        end
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        // ROM registered its word on the edge that closed StIssue.
        state_d = StResp;
        rdata_d = rom_data;
        err_d   = 1'b0;
        done_d  = owner_q ? 2'b10 : 2'b01;
      end
      StResp: begin
        state_d = StIdle;
        done_d  = 2'b00;
        last_d  = owner_q;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      owner_q       <= 1'b0;
      last_q        <= 1'b1;
      done_q        <= 2'b00;
      rdata_q       <= 32'h0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      rom_enable_q  <= 1'b0;
      rom_address_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      done_q        <= done_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      rom_enable_q  <= rom_enable_d;
      rom_address_q <= rom_address_d;
    end
  end

  assign done        = done_q;
  assign rdata       = rdata_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign rom_enable  = rom_enable_q;
  assign rom_address = rom_address_q;

endmodule
